// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory,
// and presents one held instruction at a time to decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0800,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic [4:0]  opcode,
    output logic [15:0] instr_pc,
    output logic [15:0] instr_pc_plus2,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        halted
);

    typedef enum logic [1:0] {StFetch, StHold, StHalt} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;
    logic        redir_pend_q, redir_pend_d;
    logic [15:0] redir_tgt_q, redir_tgt_d;

    logic [15:0] redirect_tgt;
    logic        fetch_discard;
    logic        held_is_halt;

    // Instructions are halfword aligned, so the target LSB is dropped.
    assign redirect_tgt  = redirect_pc & ~16'h0001;
    // A response that races with or follows a redirect belongs to a stale path.
    assign fetch_discard = redir_pend_q | redirect_valid;
    assign held_is_halt  = (instr_q[15:11] == HALT_OPCODE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect outranks stall and a same-cycle response
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (imem_rdy && !fetch_discard) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    state_d = StFetch;
                end else if (!stall) begin
                    state_d = held_is_halt ? StHalt : StFetch;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Datapath next-state: PC, held instruction and pending redirect
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        redir_pend_d  = redir_pend_q;
        redir_tgt_d   = redir_tgt_q;
        unique case (state_q)
            StFetch: begin
                if (imem_rdy) begin
                    if (fetch_discard) begin
                        // Same-cycle redirect is the most recent target.
                        pc_d         = redirect_valid ? redirect_tgt : redir_tgt_q;
                        redir_pend_d = 1'b0;
                    end else begin
                        instr_d       = imem_data;
                        instr_pc_d    = pc_q;
                        pc_d          = pc_q + 16'd2;
                        instr_valid_d = 1'b1;
                    end
                end else if (redirect_valid) begin
                    redir_pend_d = 1'b1;
                    redir_tgt_d  = redirect_tgt;
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    pc_d          = redirect_tgt;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    if (held_is_halt) begin
                        instr_d  = NOP_INSTR;
                        halted_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 16'h0000;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            redir_pend_q  <= 1'b0;
            redir_tgt_q   <= 16'h0000;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            redir_pend_q  <= redir_pend_d;
            redir_tgt_q   <= redir_tgt_d;
        end
    end

    // Outputs; the request is gated by reset so nothing is issued while held in reset
    always_comb begin
        imem_req       = rst_n && (state_q == StFetch);
        imem_addr      = pc_q;
        instr          = instr_q;
        opcode         = instr_q[15:11];
        instr_pc       = instr_pc_q;
        instr_pc_plus2 = instr_pc_q + 16'd2;
        instr_valid    = instr_valid_q;
        halted         = halted_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a delivered-instruction scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic [15:0] instr_pc;
    logic [15:0] instr_pc_plus2;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halted;

    int vectors = 0;
    int errors  = 0;

    // Memory responder controls
    int lat      = 0;
    int wait_cnt = 0;
    bit rdy_force = 1'b0;

    // Expected delivered instructions: {instr, pc}
    logic [31:0] exp_q[$];
    logic [31:0] sb_e;
    logic        prev_valid = 1'b0;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdy       (imem_rdy),
        .imem_data      (imem_data),
        .instr          (instr),
        .opcode         (opcode),
        .instr_pc       (instr_pc),
        .instr_pc_plus2 (instr_pc_plus2),
        .instr_valid    (instr_valid),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        case (a)
            16'h0000: mem_rd = 16'h4001;
            16'h0002: mem_rd = 16'h4802;
            16'h0004: mem_rd = 16'h0000;
            default:  mem_rd = {5'b01010, a[10:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick();
        bit req_now;
        bit hs;
        if ((imem_req && wait_cnt >= lat) || rdy_force) begin
            imem_rdy  = 1'b1;
            imem_data = mem_rd(imem_addr);
        end else begin
            imem_rdy  = 1'b0;
            imem_data = 16'hDEAD;
        end
        req_now = imem_req;
        hs      = imem_req && imem_rdy;
        @(posedge clk);
        if (req_now) begin
            if (hs) wait_cnt = 0;
            else wait_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req", {15'd0, imem_req}, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'h0000);
        chk("rst_valid", {15'd0, instr_valid}, 16'h0000);
        chk("rst_instr", instr, 16'h0800);
        chk("rst_instr_pc", instr_pc, 16'h0000);
        imem_rdy       = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        rdy_force      = 1'b0;
        wait_cnt       = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req", {15'd0, imem_req}, 16'h0001);
        chk("post_rst_addr", imem_addr, 16'h0000);
    endtask

    // Per-cycle output rules and scoreboard of delivered instructions
    always @(negedge clk) begin
        if (rst_n) begin
            chk("opcode_field", {11'd0, opcode}, {11'd0, instr[15:11]});
            chk("pc_plus2", instr_pc_plus2, instr_pc + 16'd2);
            if (halted) begin
                chk("halt_no_req", {15'd0, imem_req}, 16'h0000);
                chk("halt_no_valid", {15'd0, instr_valid}, 16'h0000);
            end
            if (instr_valid) chk("valid_no_req", {15'd0, imem_req}, 16'h0000);
            if (instr_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL sb_unexpected: got instr %h pc %h, expected none", instr,
                             instr_pc);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_instr", instr, sb_e[31:16]);
                    chk("sb_pc", instr_pc, sb_e[15:0]);
                end
            end
            prev_valid = instr_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Zero-latency fetch of address 0
        lat = 0;
        exp_q.push_back({16'h4001, 16'h0000});
        tick();
        chk("f0_valid", {15'd0, instr_valid}, 16'h0001);
        chk("f0_instr", instr, 16'h4001);
        chk("f0_opcode", {11'd0, opcode}, 16'h0008);
        chk("f0_plus2", instr_pc_plus2, 16'h0002);
        chk("f0_req", {15'd0, imem_req}, 16'h0000);
        tick();
        chk("f1_req", {15'd0, imem_req}, 16'h0001);
        chk("f1_addr", imem_addr, 16'h0002);
        chk("f1_valid", {15'd0, instr_valid}, 16'h0000);

        // Three wait cycles on address 2
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lat_addr", imem_addr, 16'h0002);
            chk("lat_req", {15'd0, imem_req}, 16'h0001);
            chk("lat_valid", {15'd0, instr_valid}, 16'h0000);
        end
        exp_q.push_back({16'h4802, 16'h0002});
        tick();
        chk("lat_done_valid", {15'd0, instr_valid}, 16'h0001);
        chk("lat_done_opcode", {11'd0, opcode}, 16'h0009);
        chk("lat_done_req", {15'd0, imem_req}, 16'h0000);

        // Stall in HOLD; stray rdy while not requesting must be ignored
        stall = 1'b1;
        rdy_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_valid", {15'd0, instr_valid}, 16'h0001);
            chk("stall_instr", instr, 16'h4802);
            chk("stall_pc", instr_pc, 16'h0002);
            chk("stall_req", {15'd0, imem_req}, 16'h0000);
        end
        rdy_force = 1'b0;
        stall = 1'b0;
        lat = 0;
        tick();
        chk("unstall_req", {15'd0, imem_req}, 16'h0001);
        chk("unstall_addr", imem_addr, 16'h0004);

        // HALT at address 4
        exp_q.push_back({16'h0000, 16'h0004});
        tick();
        chk("halt_held_op", {11'd0, opcode}, 16'h0000);
        tick();
        chk("halted", {15'd0, halted}, 16'h0001);
        chk("halt_instr", instr, 16'h0800);
        chk("halt_opcode", {11'd0, opcode}, 16'h0001);
        for (int i = 0; i < 10; i++) begin
            redirect_valid = (i == 3);
            redirect_pc    = 16'h1000;
            tick();
            chk("halt_req", {15'd0, imem_req}, 16'h0000);
            chk("halt_stay", {15'd0, halted}, 16'h0001);
        end
        redirect_valid = 1'b0;
        do_reset();
        chk("halt_rst_cleared", {15'd0, halted}, 16'h0000);

        // Redirect while a request is waiting
        exp_q.push_back({16'h4001, 16'h0000});
        tick();
        tick();
        chk("r_addr", imem_addr, 16'h0002);
        lat = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h1235;
        tick();
        redirect_valid = 1'b0;
        chk("r_inflight_addr", imem_addr, 16'h0002);
        chk("r_inflight_req", {15'd0, imem_req}, 16'h0001);
        tick();
        tick();
        chk("r_discard_valid", {15'd0, instr_valid}, 16'h0000);
        chk("r_new_addr", imem_addr, 16'h1234);
        chk("r_new_req", {15'd0, imem_req}, 16'h0001);
        lat = 0;
        exp_q.push_back({16'h5234, 16'h1234});
        tick();
        chk("r_fetch_valid", {15'd0, instr_valid}, 16'h0001);

        // Redirect beats stall in HOLD
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h2000;
        tick();
        stall = 1'b0;
        chk("sq_valid", {15'd0, instr_valid}, 16'h0000);
        chk("sq_instr", instr, 16'h0800);
        chk("sq_addr", imem_addr, 16'h2000);

        // Redirect coinciding with rdy discards the word; wrap at 0xFFFE
        redirect_pc = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_discard_valid", {15'd0, instr_valid}, 16'h0000);
        chk("wrap_addr", imem_addr, 16'hFFFE);
        exp_q.push_back({16'h57FE, 16'hFFFE});
        tick();
        chk("wrap_pc", instr_pc, 16'hFFFE);
        chk("wrap_plus2", instr_pc_plus2, 16'h0000);
        tick();
        chk("wrap_next_addr", imem_addr, 16'h0000);
        chk("wrap_next_req", {15'd0, imem_req}, 16'h0001);

        // Reset with a redirect pending clears it
        lat = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h3000;
        tick();
        redirect_valid = 1'b0;
        do_reset();
        lat = 0;
        exp_q.push_back({16'h4001, 16'h0000});
        tick();
        chk("pend_clr_valid", {15'd0, instr_valid}, 16'h0001);
        chk("pend_clr_instr", instr, 16'h4001);
        tick();
        chk("pend_clr_addr", imem_addr, 16'h0002);

        chk("sb_empty", exp_q.size()[15:0], 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
